// File: rtl/conv_share_arb.sv
// conv_share_arb
//   Two requesters share one streaming convolution engine. A transaction is
//   X input beats from the granted requester, forwarded to the engine,
//   followed by N = X-F+1 result beats routed back to that requester.
//   Nothing is buffered: every path is a combinational pass-through gated by
//   the FSM state and the current owner. When both requesters ask at once,
//   the grant alternates.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   sN_x_data_i/valid_i   requester N input stream (ready: sN_x_ready_o)
//   sN_y_data_o/valid_o   requester N result stream (ready: sN_y_ready_i)
//   e_x_*                 input stream toward the shared engine
//   e_y_*                 result stream from the shared engine
//   owner_o               current / last granted requester
//   busy_o                high while a transaction is in progress

// Per-requester steering: forwards this requester's streams to or from the
// engine only while it owns the engine in the matching phase, and drives
// zeros otherwise so the top level can OR the lanes together.
module conv_share_lane #(
  parameter int W = 8
) (
  input  logic         sel_load_i,
  input  logic         sel_drain_i,
  input  logic [W-1:0] x_data_i,
  input  logic         x_valid_i,
  output logic         x_ready_o,
  output logic [W-1:0] y_data_o,
  output logic         y_valid_o,
  input  logic         y_ready_i,
  input  logic         e_x_ready_i,
  input  logic [W-1:0] e_y_data_i,
  input  logic         e_y_valid_i,
  output logic [W-1:0] e_x_data_o,
  output logic         e_x_valid_o,
  output logic         e_y_ready_o
);
  assign x_ready_o   = sel_load_i & e_x_ready_i;
  assign e_x_data_o  = sel_load_i ? x_data_i : '0;
  assign e_x_valid_o = sel_load_i & x_valid_i;

  assign y_data_o    = sel_drain_i ? e_y_data_i : '0;
  assign y_valid_o   = sel_drain_i & e_y_valid_i;
  assign e_y_ready_o = sel_drain_i & y_ready_i;
endmodule

module conv_share_arb #(
  parameter int X = 16,
  parameter int F = 4,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] s0_x_data_i,
  input  logic         s0_x_valid_i,
  output logic         s0_x_ready_o,
  output logic [W-1:0] s0_y_data_o,
  output logic         s0_y_valid_o,
  input  logic         s0_y_ready_i,
  input  logic [W-1:0] s1_x_data_i,
  input  logic         s1_x_valid_i,
  output logic         s1_x_ready_o,
  output logic [W-1:0] s1_y_data_o,
  output logic         s1_y_valid_o,
  input  logic         s1_y_ready_i,
  output logic [W-1:0] e_x_data_o,
  output logic         e_x_valid_o,
  input  logic         e_x_ready_i,
  input  logic [W-1:0] e_y_data_i,
  input  logic         e_y_valid_i,
  output logic         e_y_ready_o,
  output logic         owner_o,
  output logic         busy_o
);
  localparam int NUM_LANES = 2;
  localparam int N  = X - F + 1;
  localparam int CW = $clog2(X + 1);
  localparam logic [CW-1:0] X_LAST = CW'(X - 1);
  localparam logic [CW-1:0] N_LAST = CW'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN} state_t;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic          prio_q, prio_d;
  logic [CW-1:0] in_cnt_q, in_cnt_d;
  logic [CW-1:0] out_cnt_q, out_cnt_d;

  logic [NUM_LANES-1:0][W-1:0] x_data, y_data, ex_data;
  logic [NUM_LANES-1:0]        x_valid, x_ready, y_valid, y_ready;
  logic [NUM_LANES-1:0]        ex_valid, ey_ready, sel_load, sel_drain;
  logic                        in_fire, out_fire;

  assign x_data  = {s1_x_data_i, s0_x_data_i};
  assign x_valid = {s1_x_valid_i, s0_x_valid_i};
  assign y_ready = {s1_y_ready_i, s0_y_ready_i};

  assign s0_x_ready_o = x_ready[0];
  assign s1_x_ready_o = x_ready[1];
  assign s0_y_data_o  = y_data[0];
  assign s1_y_data_o  = y_data[1];
  assign s0_y_valid_o = y_valid[0];
  assign s1_y_valid_o = y_valid[1];

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign sel_load[g]  = (state_q == S_LOAD)  && (owner_q == 1'(g));
    assign sel_drain[g] = (state_q == S_DRAIN) && (owner_q == 1'(g));

    conv_share_lane #(.W(W)) u_lane (
      .sel_load_i  (sel_load[g]),
      .sel_drain_i (sel_drain[g]),
      .x_data_i    (x_data[g]),
      .x_valid_i   (x_valid[g]),
      .x_ready_o   (x_ready[g]),
      .y_data_o    (y_data[g]),
      .y_valid_o   (y_valid[g]),
      .y_ready_i   (y_ready[g]),
      .e_x_ready_i (e_x_ready_i),
      .e_y_data_i  (e_y_data_i),
      .e_y_valid_i (e_y_valid_i),
      .e_x_data_o  (ex_data[g]),
      .e_x_valid_o (ex_valid[g]),
      .e_y_ready_o (ey_ready[g])
    );
  end

  // At most one lane is selected, the others drive zero, so OR is a mux.
  always_comb begin
    e_x_data_o  = '0;
    e_x_valid_o = 1'b0;
    e_y_ready_o = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) begin
      e_x_data_o  = e_x_data_o | ex_data[i];
      e_x_valid_o = e_x_valid_o | ex_valid[i];
      e_y_ready_o = e_y_ready_o | ey_ready[i];
    end
  end

  assign in_fire  = e_x_valid_o & e_x_ready_i;
  assign out_fire = e_y_valid_i & e_y_ready_o;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    prio_d    = prio_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (|x_valid) begin
          // Contention resolved by prio; a lone request wins outright.
          owner_d = (&x_valid) ? prio_q : x_valid[1];
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (in_fire) begin
          if (in_cnt_q == X_LAST) begin
            in_cnt_d = '0;
            state_d  = S_DRAIN;
          end else begin
            in_cnt_d = in_cnt_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (out_fire) begin
          if (out_cnt_q == N_LAST) begin
            out_cnt_d = '0;
            prio_d    = ~owner_q;   // the other requester wins the next tie
            state_d   = S_IDLE;
          end else begin
            out_cnt_d = out_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      owner_q   <= 1'b0;
      prio_q    <= 1'b0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      prio_q    <= prio_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
    end
  end

  assign owner_o = owner_q;
  assign busy_o  = (state_q != S_IDLE);
endmodule

// File: doc/conv_share_arb.md
CONV_SHARE_ARB -- requirements
Module: conv_share_arb

Interface
REQ-001 Parameter X, default 16, input vector length per transaction.
REQ-002 Parameter F, default 4, filter length of the shared engine; outputs per transaction N = X-F+1 (13 at defaults).
REQ-003 Parameter W, default 8, signed sample width.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 s0_x_data / s1_x_data  input  W  requester 0/1 input sample, signed.
REQ-007 s0_x_valid / s1_x_valid  input  1  requester 0/1 input sample valid.
REQ-008 s0_x_ready / s1_x_ready  output  1  requester 0/1 input sample accepted.
REQ-009 s0_y_data / s1_y_data  output  W  requester 0/1 result, signed.
REQ-010 s0_y_valid / s1_y_valid  output  1  requester 0/1 result valid.
REQ-011 s0_y_ready / s1_y_ready  input  1  requester 0/1 result accepted.
REQ-012 e_x_data  output  W; e_x_valid  output  1; e_x_ready  input  1  input stream to the shared conv engine.
REQ-013 e_y_data  input  W; e_y_valid  input  1; e_y_ready  output  1  result stream from the shared conv engine.
REQ-014 owner  output  1  current/last granted requester; busy  output  1  high outside IDLE.

Function
REQ-015 FSM states IDLE, LOAD, DRAIN; a transaction is exactly X accepted input beats followed by exactly N accepted output beats.
REQ-016 IDLE: all x_ready, y_valid, e_x_valid and e_y_ready are 0; if any sx_x_valid is high, register owner and go to LOAD on the next edge.
REQ-017 Simultaneous requests in IDLE: grant the requester named by priority bit prio; single request is granted regardless of prio.
REQ-018 LOAD: combinational pass-through; e_x_data = owner x_data, e_x_valid = owner x_valid, owner x_ready = e_x_ready; non-owner x_ready = 0.
REQ-019 in_cnt increments on each e_x_valid & e_x_ready beat; on the beat that makes in_cnt reach X, go to DRAIN and clear in_cnt.
REQ-020 DRAIN: owner y_data = e_y_data, owner y_valid = e_y_valid, e_y_ready = owner y_ready; e_x_valid = 0; all x_ready = 0.
REQ-021 out_cnt increments on each e_y_valid & e_y_ready beat; on the beat that makes out_cnt reach N, clear out_cnt, set prio to the non-owner, go to IDLE.
REQ-022 Non-owner y_valid and non-owner-bound data are 0 at all times; y_data of a port not in DRAIN-ownership is 0.
REQ-023 Requester x_valid deasserting mid-LOAD stalls the transaction (no timeout); owner y_ready low in DRAIN stalls the engine via e_y_ready.
REQ-024 A request arriving during LOAD/DRAIN is ignored until IDLE; a request held across the IDLE cycle is granted with at most one idle cycle between transactions.
REQ-025 Arbitration latency: first input beat can pass no earlier than the cycle after the request is seen in IDLE.
REQ-026 Data is never modified; the block performs no arithmetic beyond counter compares (counters $clog2(X+1) bits).
REQ-027 Engine output arriving while not in DRAIN is not accepted (e_y_ready = 0).

Reset
REQ-028 On reset: state IDLE, in_cnt = 0, out_cnt = 0, prio = 0, owner = 0, busy = 0; all ready/valid outputs 0 in the cycle following reset.
REQ-029 Reset mid-LOAD or mid-DRAIN aborts the transaction with no further beats forwarded; the shared engine is reset by the same reset signal.

Verification
REQ-030 Only s0 requests, 16 samples 1..16, engine model with filter {-6,10,4,-8} -> s0 receives 13 results matching the saturating ReLU reference, s1 ports idle throughout.
REQ-031 s0 and s1 both valid at the first post-reset IDLE -> s0 granted (owner=0); next transaction granted to s1; then s0 again (strict alternation).
REQ-032 s1 only, with x_valid dropped for 3 cycles after beat 5 -> in_cnt holds at 5, transaction completes after 16 beats, 13 results on s1.
REQ-033 s0 in DRAIN with s0_y_ready low for 10 cycles -> e_y_ready low, no result lost or duplicated, s1 request stays pending until IDLE.
REQ-034 Reset asserted after 8 LOAD beats -> next cycle IDLE, busy = 0, prio = 0; a fresh s0 transaction completes correctly.
REQ-035 Back-to-back s1 requests with s0 idle -> consecutive s1 transactions separated by exactly one IDLE cycle.
